mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single-port 1024x16 synchronous RAM between the CPU memory port and a secondary IO/DMA master, such as a display fetch or loader. It sits between the CPU's `write_en`/`addr`/`data_in`/`data_out` port and the RAM. It grants at most one access per cycle and routes one-cycle-latency read data back to the requester that issued the read. CPU has fixed priority. An optional starvation guard bounds the IO master's wait.

## Interface
- `ADDR_W`, 10, RAM word-address width.
- `DATA_W`, 16, RAM data width.
- `STARVE_LIMIT`, 4, consecutive denied IO cycles before IO is forced a grant (used only with the starvation guard).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `cpu_req` in 1: CPU access request.
- `cpu_we` in 1: CPU write when 1, read when 0.
- `cpu_addr` in ADDR_W: CPU word address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_gnt` out 1: CPU access performed at this clock edge.
- `cpu_rvalid` out 1: `cpu_rdata` holds the CPU's read result.
- `cpu_rdata` out DATA_W: read data.
- `io_req`, `io_we`, `io_addr`, `io_wdata`, `io_gnt`, `io_rvalid`, `io_rdata`: identical to the CPU ports, for the IO master.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out DATA_W: RAM write data (RAM `data_in`).
- `ram_rdata` in DATA_W: RAM registered output (RAM `data_out`). Valid the cycle after the address is presented.

## Operation
- **Handshake**
  - A requester raises `req` and holds `we`, `addr` and `wdata` stable until it samples `gnt=1` at a rising edge.
  - The access completes at that edge.
  - The requester may keep `req` high with new fields in the next cycle, giving back-to-back accesses.
- **Grant**
  - `cpu_gnt` and `io_gnt` are combinational from the requests and registered state, and are never both 1.
  - Base rule: `cpu_gnt = cpu_req`, and `io_gnt = io_req & ~cpu_req`.
- **RAM mux**
  - `ram_*` carry the granted requester's fields.
  - With no grant: `ram_we=0`, `ram_addr=0`, `ram_wdata=0`.
- **Response tracking**
  - Register `rsp_owner ∈ {NONE, CPU, IO}` captures the owner of a granted read (`we=0`) at each edge.
  - It is NONE after a write or an idle cycle.
  - `cpu_rvalid = (rsp_owner==CPU)` and `io_rvalid = (rsp_owner==IO)`.
  - `cpu_rdata` and `io_rdata` both equal `ram_rdata`. They are qualified only by `rvalid`.
- **Writes** produce no `rvalid`. RAM write-through on `data_out` is ignored.
- **Address width:** addresses are taken modulo 2^ADDR_W with no bounds check. Address 1023 followed by 0 is legal.

## Timing
- **Latency:** grant is in the same cycle as the request when uncontested. Read data and `rvalid` appear exactly 1 cycle after the granting edge.
- **Throughput:** one access per cycle. The CPU's 3-cycle instruction timing is unchanged when IO is idle.
- **Reset values**
  - `rsp_owner=NONE`, so both `rvalid=0`.
  - Starvation counter = 0.
  - While `reset=1`, both `gnt` outputs and `ram_we` are forced to 0 and `ram_addr`/`ram_wdata` are forced to 0.
- **Reset mid-operation:** a read granted before reset asserts loses its response (`rvalid` is cleared asynchronously). The requester must reissue it. No RAM write occurs while reset is high.
- **Simultaneous requests:** CPU wins unless the starvation guard forces IO.
- **Simultaneous read response and new grant:** this is normal pipelining. The `rvalid` for access N and the grant of access N+1 coexist.

## Configuration
- **`MEM_ARB_STARVE_EN` defined**
  - A counter increments each cycle with `io_req & ~io_gnt`, saturating at STARVE_LIMIT.
  - It clears on `io_gnt`, or when `io_req=0`.
  - When the counter equals STARVE_LIMIT, the next cycle forces `io_gnt=io_req` and `cpu_gnt=0` for exactly one access. The CPU stalls that cycle.
- **`MEM_ARB_STARVE_EN` undefined:** no counter is present. Strict CPU priority applies and IO may starve indefinitely.

## Structure
- Package `mem_arb_pkg` holds:
  - `ADDR_W`/`DATA_W` defaults.
  - The `owner_t` enum {OWN_NONE, OWN_CPU, OWN_IO}.
- Sub-module `mem_arb_starve_ctr` (counter, saturation and force output) is instantiated only under `MEM_ARB_STARVE_EN`.

## Test plan
- **Reset:** hold `reset=1` with both `req=1` -> `gnt=0`, `ram_we=0`, `rvalid=0`. After release, CPU is granted the same cycle.
- **CPU write then read:** CPU writes 16'd233 to address 10, then reads address 10 -> `cpu_gnt` both cycles, `cpu_rvalid=1` with `cpu_rdata=233` one cycle after the read grant, and `io_rvalid=0` throughout.
- **Contention:** both request, CPU reads address 5, IO reads address 6 -> CPU granted first. IO is granted the cycle after `cpu_req` drops, and `io_rdata` = RAM[6] with only `io_rvalid` set.
- **Starvation (`MEM_ARB_STARVE_EN`, STARVE_LIMIT=4):** `cpu_req` held high continuously, `io_req` high -> `io_gnt` pulses once after 4 denied cycles, `cpu_gnt=0` that cycle, then the counter restarts.
- **Wrap and back-to-back:** IO reads addresses 1022, 1023, 0 on consecutive cycles -> three consecutive `io_rvalid` cycles returning the correct words.
- **Reset mid-read:** CPU read granted, then `reset` pulses high 2 ns after the edge -> `cpu_rvalid` falls immediately. After re-issue the correct data returns.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: default widths,
// starvation limit and the read-response owner encoding.
package mem_arb_pkg;

  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_DATA_W       = 16;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_IO   = 2'd2
  } owner_t;

  // Owner of the response that the RAM returns one cycle after this grant.
  function automatic owner_t next_owner(input logic cpu_gnt, input logic cpu_we,
                                        input logic io_gnt, input logic io_we);
    if (cpu_gnt && !cpu_we) return OWN_CPU;
    if (io_gnt && !io_we)   return OWN_IO;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Starvation counter for the IO master. Counts consecutive cycles in which
// IO requests but is denied, saturating at STARVE_LIMIT; once saturated it
// asks the arbiter to hand the next access to IO.
module mem_arb_starve_ctr import mem_arb_pkg::*; #(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic io_req,
  input  logic io_gnt,
  output logic force_io
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // Next count: clear when IO is served or stops asking, else saturating +1.
  always_comb begin
    w_cnt_next = r_cnt;
    if (!io_req || io_gnt) begin
      w_cnt_next = '0;
    end else if (r_cnt != LIMIT_V) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign force_io = (r_cnt == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// CPU has fixed priority; read data (one-cycle latency) is steered back to
// whichever requester issued the read. Define MEM_ARB_STARVE_EN to add the
// IO starvation guard (mem_arb_starve_ctr).
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be at least 1");
  end

  logic   w_force_io;
  owner_t r_rsp_owner;
  owner_t w_rsp_owner_next;

`ifdef MEM_ARB_STARVE_EN
  mem_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .reset    (reset),
    .io_req   (io_req),
    .io_gnt   (io_gnt),
    .force_io (w_force_io)
  );
`else
  // Strict CPU priority: IO is never forced through.
  assign w_force_io = 1'b0;
`endif

  // Grant: CPU wins unless IO is being forced; nothing is granted in reset.
  always_comb begin
    cpu_gnt = 1'b0;
    io_gnt  = 1'b0;
    if (!reset) begin
      cpu_gnt = cpu_req & ~w_force_io;
      io_gnt  = io_req & (~cpu_req | w_force_io);
    end
  end

  // RAM mux: granted requester's fields, all zero when idle.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_gnt) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (io_gnt) begin
      ram_we    = io_we;
      ram_addr  = io_addr;
      ram_wdata = io_wdata;
    end
  end

  // Response owner for the data the RAM presents next cycle.
  always_comb begin
    w_rsp_owner_next = next_owner(cpu_gnt, cpu_we, io_gnt, io_we);
  end

  // Response owner register; reset drops any in-flight read response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_owner <= OWN_NONE;
    end else begin
      r_rsp_owner <= w_rsp_owner_next;
    end
  end

  assign cpu_rvalid = (r_rsp_owner == OWN_CPU);
  assign io_rvalid  = (r_rsp_owner == OWN_IO);
  assign cpu_rdata  = ram_rdata;
  assign io_rdata   = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural 1024x16 RAM.
// Expected read responses are pushed to a scoreboard queue when a read is
// granted and popped one cycle later when rvalid is due.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 16;

  typedef struct packed {
    logic          cpu;
    logic          io;
    logic [DW-1:0] data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, io_req, io_we;
  logic [AW-1:0] cpu_addr, io_addr;
  logic [DW-1:0] cpu_wdata, io_wdata;
  logic          cpu_gnt, cpu_rvalid, io_gnt, io_rvalid;
  logic [DW-1:0] cpu_rdata, io_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  logic [DW-1:0] ram_mem [1024];
  bit            ram_vld [1024];
  logic [DW-1:0] shadow [1024];
  bit            shadow_vld [1024];

  rsp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Power-up RAM contents are a fixed function of the address.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {a[5:0], a} ^ 16'h5AC3;
  endfunction

  // Behavioural synchronous RAM with registered output.
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
      ram_vld[ram_addr] <= 1'b1;
    end
    ram_rdata <= ram_vld[ram_addr] ? ram_mem[ram_addr] : init_word(ram_addr);
  end

  function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
    return shadow_vld[a] ? shadow[a] : init_word(a);
  endfunction

  // Expected {ram_we, ram_addr, ram_wdata} for the given expected grants.
  function automatic logic [AW+DW:0] exp_ram(input bit gc, input bit gi);
    if (gc) return {cpu_we, cpu_addr, cpu_wdata};
    if (gi) return {io_we, io_addr, io_wdata};
    return '0;
  endfunction

  task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic ir, input logic iw,
                       input logic [AW-1:0] ia, input logic [DW-1:0] id);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    io_req  = ir; io_we  = iw; io_addr  = ia; io_wdata  = id;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Record the effect of the expected grant: shadow write or pending read.
  task automatic sb_push(input bit gc, input bit gi);
    rsp_t e;
    e = '0;
    if (gc) begin
      if (cpu_we) begin shadow[cpu_addr] = cpu_wdata; shadow_vld[cpu_addr] = 1'b1; end
      else begin e.cpu = 1'b1; e.data = rd_word(cpu_addr); end
    end else if (gi) begin
      if (io_we) begin shadow[io_addr] = io_wdata; shadow_vld[io_addr] = 1'b1; end
      else begin e.io = 1'b1; e.data = rd_word(io_addr); end
    end
    sb_q.push_back(e);
  endtask

  task automatic restart_sb();
    sb_q.delete();
    sb_q.push_back('0);
  endtask

  task automatic test_reset();
    rsp_t e;
    logic [AW+DW:0] er;
    bit gc, gi;
    drive(1'b1, 1'b1, 10'd7, 16'hBEEF, 1'b1, 1'b1, 10'd8, 16'h1234);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({cpu_gnt, io_gnt, ram_we, ram_addr, ram_wdata, cpu_rvalid, io_rvalid} !== '0) begin
        n_bad++;
        $display("FAIL reset_hold[%0d] got gnt=%b%b we=%b addr=%h wd=%h rv=%b%b want all 0",
                 k, cpu_gnt, io_gnt, ram_we, ram_addr, ram_wdata, cpu_rvalid, io_rvalid);
      end else $display("reset_hold[%0d] outputs quiet", k);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    restart_sb();
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: drive(1'b1, 1'b0, 10'd3, '0, 1'b1, 1'b0, 10'd4, '0);
        default: idle();
      endcase
      gc = (k == 0); gi = 1'b0;
      @(negedge clk);
      e = sb_q.pop_front();
      n_cmp++;
      if (cpu_rvalid !== e.cpu || io_rvalid !== e.io || (e.cpu && cpu_rdata !== e.data) ||
          (e.io && io_rdata !== e.data)) begin
        n_bad++;
        $display("FAIL reset_rsp[%0d] got rv=%b%b rdata=%h/%h want rv=%b%b data=%h",
                 k, cpu_rvalid, io_rvalid, cpu_rdata, io_rdata, e.cpu, e.io, e.data);
      end else $display("reset_rsp[%0d] rv=%b%b data=%h", k, e.cpu, e.io, e.data);
      er = exp_ram(gc, gi);
      n_cmp++;
      if ({cpu_gnt, io_gnt, ram_we, ram_addr, ram_wdata} !== {gc, gi, er}) begin
        n_bad++;
        $display("FAIL reset_gnt[%0d] got gnt=%b%b ram=%h want gnt=%b%b ram=%h",
                 k, cpu_gnt, io_gnt, {ram_we, ram_addr, ram_wdata}, gc, gi, er);
      end
      sb_push(gc, gi);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cpu_write_read();
    rsp_t e;
    logic [AW+DW:0] er;
    bit gc, gi;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive(1'b1, 1'b1, 10'd10, 16'd233, 1'b0, 1'b0, '0, '0);
        1: drive(1'b1, 1'b0, 10'd10, '0, 1'b0, 1'b0, '0, '0);
        default: idle();
      endcase
      gc = (k < 2); gi = 1'b0;
      @(negedge clk);
      e = sb_q.pop_front();
      n_cmp++;
      if (cpu_rvalid !== e.cpu || io_rvalid !== e.io || (e.cpu && cpu_rdata !== e.data) ||
          (e.io && io_rdata !== e.data)) begin
        n_bad++;
        $display("FAIL wr_rd_rsp[%0d] got rv=%b%b rdata=%h/%h want rv=%b%b data=%h",
                 k, cpu_rvalid, io_rvalid, cpu_rdata, io_rdata, e.cpu, e.io, e.data);
      end else $display("wr_rd_rsp[%0d] rv=%b%b data=%h", k, e.cpu, e.io, e.data);
      er = exp_ram(gc, gi);
      n_cmp++;
      if ({cpu_gnt, io_gnt, ram_we, ram_addr, ram_wdata} !== {gc, gi, er}) begin
        n_bad++;
        $display("FAIL wr_rd_gnt[%0d] got gnt=%b%b ram=%h want gnt=%b%b ram=%h",
                 k, cpu_gnt, io_gnt, {ram_we, ram_addr, ram_wdata}, gc, gi, er);
      end
      sb_push(gc, gi);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_contention();
    rsp_t e;
    logic [AW+DW:0] er;
    bit gc, gi;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive(1'b1, 1'b0, 10'd5, '0, 1'b1, 1'b0, 10'd6, '0);
        1: drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd6, '0);
        default: idle();
      endcase
      gc = (k == 0); gi = (k == 1);
      @(negedge clk);
      e = sb_q.pop_front();
      n_cmp++;
      if (cpu_rvalid !== e.cpu || io_rvalid !== e.io || (e.cpu && cpu_rdata !== e.data) ||
          (e.io && io_rdata !== e.data)) begin
        n_bad++;
        $display("FAIL contend_rsp[%0d] got rv=%b%b rdata=%h/%h want rv=%b%b data=%h",
                 k, cpu_rvalid, io_rvalid, cpu_rdata, io_rdata, e.cpu, e.io, e.data);
      end else $display("contend_rsp[%0d] rv=%b%b data=%h", k, e.cpu, e.io, e.data);
      er = exp_ram(gc, gi);
      n_cmp++;
      if ({cpu_gnt, io_gnt, ram_we, ram_addr, ram_wdata} !== {gc, gi, er}) begin
        n_bad++;
        $display("FAIL contend_gnt[%0d] got gnt=%b%b ram=%h want gnt=%b%b ram=%h",
                 k, cpu_gnt, io_gnt, {ram_we, ram_addr, ram_wdata}, gc, gi, er);
      end
      sb_push(gc, gi);
      @(posedge clk); #1;
    end
  endtask

  // CPU requests every cycle; IO either breaks through every fifth cycle
  // (guard present, limit 4) or never gets in (strict priority).
  task automatic test_starvation();
    rsp_t e;
    logic [AW+DW:0] er;
    bit gc, gi;
    for (int k = 0; k < 12; k++) begin
      if (k < 10) drive(1'b1, 1'b0, 10'd20, '0, 1'b1, 1'b0, 10'd200, '0);
      else idle();
`ifdef MEM_ARB_STARVE_EN
      gi = (k == 4) || (k == 9);
      gc = (k < 10) && !gi;
`else
      gi = 1'b0;
      gc = (k < 10);
`endif
      @(negedge clk);
      e = sb_q.pop_front();
      n_cmp++;
      if (cpu_rvalid !== e.cpu || io_rvalid !== e.io || (e.cpu && cpu_rdata !== e.data) ||
          (e.io && io_rdata !== e.data)) begin
        n_bad++;
        $display("FAIL starve_rsp[%0d] got rv=%b%b rdata=%h/%h want rv=%b%b data=%h",
                 k, cpu_rvalid, io_rvalid, cpu_rdata, io_rdata, e.cpu, e.io, e.data);
      end else $display("starve_rsp[%0d] rv=%b%b data=%h", k, e.cpu, e.io, e.data);
      er = exp_ram(gc, gi);
      n_cmp++;
      if ({cpu_gnt, io_gnt, ram_we, ram_addr, ram_wdata} !== {gc, gi, er}) begin
        n_bad++;
        $display("FAIL starve_gnt[%0d] got gnt=%b%b ram=%h want gnt=%b%b ram=%h",
                 k, cpu_gnt, io_gnt, {ram_we, ram_addr, ram_wdata}, gc, gi, er);
      end
      sb_push(gc, gi);
      @(posedge clk); #1;
    end
  endtask

  // CPU writes 1022, 1023, 0 back to back, then IO reads them back to back.
  task automatic test_wrap_b2b();
    rsp_t e;
    logic [AW+DW:0] er;
    bit gc, gi;
    logic [AW-1:0] adr;
    for (int k = 0; k < 8; k++) begin
      adr = AW'(1022 + (k % 3));
      if (k < 3) drive(1'b1, 1'b1, adr, 16'hA1A1 + DW'(k), 1'b0, 1'b0, '0, '0);
      else if (k < 6) drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, adr, '0);
      else idle();
      gc = (k < 3); gi = (k >= 3) && (k < 6);
      @(negedge clk);
      e = sb_q.pop_front();
      n_cmp++;
      if (cpu_rvalid !== e.cpu || io_rvalid !== e.io || (e.cpu && cpu_rdata !== e.data) ||
          (e.io && io_rdata !== e.data)) begin
        n_bad++;
        $display("FAIL wrap_rsp[%0d] got rv=%b%b rdata=%h/%h want rv=%b%b data=%h",
                 k, cpu_rvalid, io_rvalid, cpu_rdata, io_rdata, e.cpu, e.io, e.data);
      end else $display("wrap_rsp[%0d] rv=%b%b data=%h", k, e.cpu, e.io, e.data);
      er = exp_ram(gc, gi);
      n_cmp++;
      if ({cpu_gnt, io_gnt, ram_we, ram_addr, ram_wdata} !== {gc, gi, er}) begin
        n_bad++;
        $display("FAIL wrap_gnt[%0d] got gnt=%b%b ram=%h want gnt=%b%b ram=%h",
                 k, cpu_gnt, io_gnt, {ram_we, ram_addr, ram_wdata}, gc, gi, er);
      end
      sb_push(gc, gi);
      @(posedge clk); #1;
    end
  endtask

  // A CPU read is granted, reset hits 2 ns after the edge, the read is reissued.
  task automatic test_reset_mid_read();
    rsp_t e;
    logic [AW+DW:0] er;
    bit gc, gi;
    drive(1'b1, 1'b0, 10'd10, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    void'(sb_q.pop_front());
    sb_push(1'b1, 1'b0);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    n_cmp++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== e.data) begin
      n_bad++;
      $display("FAIL midrst_pre got rv=%b rdata=%h want rv=1 data=%h", cpu_rvalid, cpu_rdata, e.data);
    end else $display("midrst_pre cpu rv=1 data=%h", e.data);
    #1 reset = 1'b1;
    drive(1'b1, 1'b1, 10'd10, 16'hDEAD, 1'b1, 1'b1, 10'd10, 16'hBEEF);
    #1;
    n_cmp++;
    if ({cpu_rvalid, io_rvalid, cpu_gnt, io_gnt, ram_we} !== 5'b0) begin
      n_bad++;
      $display("FAIL midrst_clear got rv=%b%b gnt=%b%b we=%b want 0",
               cpu_rvalid, io_rvalid, cpu_gnt, io_gnt, ram_we);
    end else $display("midrst_clear response dropped");
    @(posedge clk); #1;
    reset = 1'b0;
    restart_sb();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) drive(1'b1, 1'b0, 10'd10, '0, 1'b0, 1'b0, '0, '0);
      else idle();
      gc = (k == 0); gi = 1'b0;
      @(negedge clk);
      e = sb_q.pop_front();
      n_cmp++;
      if (cpu_rvalid !== e.cpu || io_rvalid !== e.io || (e.cpu && cpu_rdata !== e.data) ||
          (e.io && io_rdata !== e.data)) begin
        n_bad++;
        $display("FAIL midrst_rsp[%0d] got rv=%b%b rdata=%h/%h want rv=%b%b data=%h",
                 k, cpu_rvalid, io_rvalid, cpu_rdata, io_rdata, e.cpu, e.io, e.data);
      end else $display("midrst_rsp[%0d] rv=%b%b data=%h", k, e.cpu, e.io, e.data);
      er = exp_ram(gc, gi);
      n_cmp++;
      if ({cpu_gnt, io_gnt, ram_we, ram_addr, ram_wdata} !== {gc, gi, er}) begin
        n_bad++;
        $display("FAIL midrst_gnt[%0d] got gnt=%b%b ram=%h want gnt=%b%b ram=%h",
                 k, cpu_gnt, io_gnt, {ram_we, ram_addr, ram_wdata}, gc, gi, er);
      end
      sb_push(gc, gi);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_cpu_write_read();
    test_contention();
    test_starvation();
    test_wrap_b2b();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
